proj_ext_collector: RTL and testbench

- Sits directly downstream of the fragment extender stage.
- Consumes its per-cycle stream of signed extension indices and FRAG_PART-bit fragment slices.
- Reassembles each group of FRAG_LEN/FRAG_PART slices into a full fragment record {index, fragment}.
- Buffers records in a small FIFO with a valid/ready interface toward the comparison stage, and flags negative indices and dropped records.

---
 rtl/proj_ext_collector_if.sv | 28 ++
 rtl/proj_ext_collector.sv | 125 ++++++++++++
 tb/tb_proj_ext_collector.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/proj_ext_collector_if.sv
// Collector-facing bundle: extender beat stream in, fragment records out.
// The collector uses the slave view; the feeding/consuming side uses master.
interface proj_ext_collector_if #(
    parameter int FRAG_LEN          = 8,
    parameter int FRAG_PART         = 2,
    parameter int SIGNED_INDICE_LEN = 6
);
    logic                         in_valid;
    logic [SIGNED_INDICE_LEN-1:0] in_index;
    logic [FRAG_PART-1:0]         in_gfm;
    logic                         out_valid;
    logic                         out_ready;
    logic [SIGNED_INDICE_LEN-1:0] out_index;
    logic [FRAG_LEN-1:0]          out_fragment;
    logic                         out_neg;
    logic                         out_last;
    logic                         overflow;

    modport master (
        output in_valid, in_index, in_gfm, out_ready,
        input  out_valid, out_index, out_fragment, out_neg, out_last, overflow
    );

    modport slave (
        input  in_valid, in_index, in_gfm, out_ready,
        output out_valid, out_index, out_fragment, out_neg, out_last, overflow
    );
endinterface

// File: rtl/proj_ext_collector.sv
// Reassembles extender slices into {index, fragment} records and queues them in a small FIFO.
// Latency: head valid one cycle after the last slice; upstream never stalls, full FIFO drops and sets sticky overflow.
module proj_ext_collector #(
    parameter int FRAG_LEN          = 8,
    parameter int FRAG_PART         = 2,
    parameter int INDICES_COUNT     = 3,
    parameter int SIGNED_INDICE_LEN = 6,
    parameter int FIFO_DEPTH        = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    proj_ext_collector_if.slave  bus
);
    localparam int PARTS = FRAG_LEN / FRAG_PART;
    localparam int PW    = (PARTS > 1) ? $clog2(PARTS) : 1;
    localparam int RW    = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    typedef struct packed {
        logic [SIGNED_INDICE_LEN-1:0] idx;
        logic [FRAG_LEN-1:0]          frag;
        logic                         last;
    } rec_t;

    logic [PW-1:0]                part_cnt;
    logic [RW-1:0]                rec_cnt;
    logic [SIGNED_INDICE_LEN-1:0] idx_q;
    logic [FRAG_LEN-1:0]          frag_q;
    logic [FRAG_LEN-1:0]          frag_nxt;
    rec_t                         mem [FIFO_DEPTH];
    rec_t                         new_rec;
    rec_t                         head;
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic [CW-1:0]                count;
    logic                         ovf_q;
    logic                         last_part;
    logic                         last_rec;
    logic                         complete;
    logic                         full;
    logic                         pop;
    logic                         push;
    logic                         drop;

    always_comb begin
        frag_nxt = frag_q;
        for (int i = 0; i < PARTS; i++) begin
            if (bus.in_valid && part_cnt == PW'(i)) begin
                frag_nxt[i*FRAG_PART +: FRAG_PART] = bus.in_gfm;
            end
        end
    end

    assign last_part = (part_cnt == PW'(PARTS - 1));
    assign last_rec  = (rec_cnt == RW'(INDICES_COUNT - 1));
    assign complete  = bus.in_valid && last_part;

    // Index of a single-part record comes straight from the beat.
    assign new_rec.idx  = (part_cnt == '0) ? bus.in_index : idx_q;
    assign new_rec.frag = frag_nxt;
    assign new_rec.last = last_rec;

    assign full = (count == CW'(FIFO_DEPTH));
    assign pop  = (count != '0) && bus.out_ready;
    assign push = complete && (!full || pop);
    assign drop = complete && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_cnt <= '0;
            rec_cnt  <= '0;
            idx_q    <= '0;
            frag_q   <= '0;
        end else begin
            if (bus.in_valid) begin
                frag_q   <= frag_nxt;
                part_cnt <= last_part ? '0 : part_cnt + 1'b1;
                if (part_cnt == '0) begin
                    idx_q <= bus.in_index;
                end
            end
            if (complete) begin
                rec_cnt <= last_rec ? '0 : rec_cnt + 1'b1;
            end
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_rec;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign head             = mem[rd_ptr];
    assign bus.out_valid    = (count != '0);
    assign bus.out_index    = head.idx;
    assign bus.out_fragment = head.frag;
    assign bus.out_neg      = head.idx[SIGNED_INDICE_LEN-1];
    assign bus.out_last     = head.last;
    assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_proj_ext_collector.sv
// Directed bench for proj_ext_collector: expected records are queued as beats are driven
// and compared against the FIFO head whenever a pop handshake is observed.
module tb_proj_ext_collector;
    localparam int FL  = 8;
    localparam int FP  = 2;
    localparam int IC  = 3;
    localparam int SIL = 6;
    localparam int FD  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    proj_ext_collector_if #(.FRAG_LEN(FL), .FRAG_PART(FP), .SIGNED_INDICE_LEN(SIL)) bus ();

    proj_ext_collector #(
        .FRAG_LEN(FL), .FRAG_PART(FP), .INDICES_COUNT(IC),
        .SIGNED_INDICE_LEN(SIL), .FIFO_DEPTH(FD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [SIL-1:0] idx;
        logic [FL-1:0]  frag;
        logic           last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_r  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        assert (act === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, req);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rec_index", 32'(bus.out_index), 32'(e.idx));
                check("rec_fragment", 32'(bus.out_fragment), 32'(e.frag));
                check("rec_neg", 32'(bus.out_neg), 32'(e.idx[SIL-1]));
                check("rec_last", 32'(bus.out_last), 32'(e.last));
            end
        end
    end

    task automatic beat(input logic v, input logic [SIL-1:0] idx, input logic [FP-1:0] g);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.in_index = idx;
        bus.in_gfm   = g;
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 6'h15, 2'b00);
    endtask

    // Drives one record; later-part index values are scrambled and must be ignored.
    task automatic send_record(input logic [SIL-1:0] idx, input logic [FL-1:0] frag,
                               input bit keep, input int gap, input bit chk_lat, input bit rdy_last);
        exp_t e;
        e.idx  = idx;
        e.frag = frag;
        e.last = (exp_r == IC - 1);
        exp_r  = (exp_r + 1) % IC;
        if (keep) sb.push_back(e);
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, (i == 0) ? idx : (idx ^ 6'h2A), frag[2*i +: 2]);
            if (i == 3 && rdy_last) bus.out_ready = 1'b1;
            if (i == 1) begin
                for (int k = 0; k < gap; k++) begin
                    beat(1'b0, idx ^ 6'h11, 2'b11);
                    check("gap_no_output", 32'(bus.out_valid), 32'd0);
                end
            end
        end
        if (chk_lat) check("lat_not_early", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (chk_lat) check("lat_valid", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        exp_r = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_index  = '0;
        bus.in_gfm    = '0;
        bus.out_ready = 1'b0;
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_out_index", 32'(bus.out_index), 32'd0);
        check("rst_out_fragment", 32'(bus.out_fragment), 32'd0);
        check("rst_out_neg", 32'(bus.out_neg), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic assembly
        bus.out_ready = 1'b1;
        send_record(6'd5, 8'h39, 1'b1, 0, 1'b1, 1'b0);
        check("t1_index", 32'(bus.out_index), 32'd5);
        check("t1_fragment", 32'(bus.out_fragment), 32'h39);
        check("t1_neg", 32'(bus.out_neg), 32'd0);
        check("t1_last", 32'(bus.out_last), 32'd0);
        idle(3);

        // Negative index and set wrap
        do_reset();
        bus.out_ready = 1'b1;
        send_record(6'h3E, 8'hA5, 1'b1, 0, 1'b1, 1'b0);
        check("t2_neg_first", 32'(bus.out_neg), 32'd1);
        send_record(6'd0, 8'h5A, 1'b1, 0, 1'b0, 1'b0);
        send_record(6'd9, 8'hFF, 1'b1, 0, 1'b0, 1'b0);
        check("t2_last_third", 32'(bus.out_last), 32'd1);
        send_record(6'd7, 8'h00, 1'b1, 0, 1'b0, 1'b0);
        check("t2_last_fourth", 32'(bus.out_last), 32'd0);
        idle(3);

        // Idle beats mid-record
        send_record(6'd5, 8'h39, 1'b1, 3, 1'b1, 1'b0);
        check("t3_fragment", 32'(bus.out_fragment), 32'h39);
        idle(3);

        // Backpressure and overflow
        bus.out_ready = 1'b0;
        send_record(6'd1, 8'h11, 1'b1, 0, 1'b0, 1'b0);
        send_record(6'd2, 8'h22, 1'b1, 0, 1'b0, 1'b0);
        send_record(6'd3, 8'h33, 1'b0, 0, 1'b0, 1'b0);
        check("t4_overflow", 32'(bus.overflow), 32'd1);
        check("t4_valid", 32'(bus.out_valid), 32'd1);
        check("t4_head_index", 32'(bus.out_index), 32'd1);
        idle(2);
        check("t4_head_stable", 32'(bus.out_index), 32'd1);
        check("t4_frag_stable", 32'(bus.out_fragment), 32'h11);
        bus.out_ready = 1'b1;
        idle(4);
        check("t4_drained", 32'(bus.out_valid), 32'd0);
        check("t4_overflow_sticky", 32'(bus.overflow), 32'd1);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);

        // Full with simultaneous pop
        do_reset();
        bus.out_ready = 1'b0;
        send_record(6'd10, 8'h0F, 1'b1, 0, 1'b0, 1'b0);
        send_record(6'd11, 8'hF0, 1'b1, 0, 1'b0, 1'b0);
        check("t5_full_valid", 32'(bus.out_valid), 32'd1);
        send_record(6'd12, 8'h3C, 1'b1, 0, 1'b0, 1'b1);
        check("t5_no_overflow", 32'(bus.overflow), 32'd0);
        idle(5);
        check("t5_overflow_clear", 32'(bus.overflow), 32'd0);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-record
        bus.out_ready = 1'b0;
        send_record(6'd4, 8'h77, 1'b0, 0, 1'b0, 1'b0);
        check("t6_pre_valid", 32'(bus.out_valid), 32'd1);
        beat(1'b1, 6'd20, 2'b11);
        beat(1'b1, 6'd21, 2'b11);
        beat(1'b1, 6'd22, 2'b11);
        @(posedge clk);
        #3;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(bus.out_valid), 32'd0);
        check("t6_async_fragment", 32'(bus.out_fragment), 32'd0);
        check("t6_async_index", 32'(bus.out_index), 32'd0);
        sb.delete();
        exp_r = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send_record(6'd6, 8'hC6, 1'b1, 0, 1'b1, 1'b0);
        check("t6_fragment", 32'(bus.out_fragment), 32'hC6);
        check("t6_last", 32'(bus.out_last), 32'd0);
        idle(3);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
